// File: rtl/fpu_result_checker.sv
// Result checker for FPU unit benches: queues expected doubles, repacks each
// 81-bit FPU result to IEEE double, compares, and tracks pass/fail status.
module fpu_result_checker #(
    parameter int DEPTH     = 8,
    parameter int IDX_W     = 24,
    parameter bit STOP_FAIL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] total_vec,
    input  logic             exp_valid,
    input  logic [63:0]      exp_data,
    input  logic             dut_valid,
    input  logic [80:0]      dut_res,
    output logic             chk_pulse,
    output logic             chk_fail,
    output logic [63:0]      got_dbl,
    output logic [63:0]      exp_dbl,
    output logic [IDX_W-1:0] match_cnt,
    output logic [IDX_W-1:0] fail_cnt,
    output logic [IDX_W-1:0] first_fail,
    output logic             ovf_err,
    output logic             unf_err,
    output logic [1:0]       state
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FAIL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [63:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [IDX_W-1:0]   r_vec_idx, r_total;
    logic [IDX_W-1:0]   r_match_cnt, r_fail_cnt, r_first_fail;
    logic               r_chk_pulse, r_chk_fail, r_ovf_err, r_unf_err;
    logic [63:0]        r_got_dbl, r_exp_dbl;

    logic               w_run, w_start_ok, w_empty, w_full;
    logic               w_push, w_pop, w_ovf, w_unf, w_mis, w_last;
    logic [63:0]        w_got, w_exp;
    logic [IDX_W-1:0]   w_vec_nxt;

    assign w_run      = (r_state == S_RUN);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees a slot, so a push while full is accepted when paired with one.
    assign w_pop  = w_run && dut_valid && !w_empty;
    assign w_push = w_run && exp_valid && (!w_full || w_pop);
    assign w_ovf  = w_run && exp_valid && w_full && !w_pop;
    assign w_unf  = w_run && dut_valid && w_empty;

    // Extended format keeps the double's exponent MSB at bit 80.
    assign w_got     = {dut_res[63], dut_res[80], dut_res[61:0]};
    assign w_exp     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_mis     = (w_got != w_exp);
    assign w_vec_nxt = r_vec_idx + IDX_W'(1);
    assign w_last    = (r_total != '0) && (w_vec_nxt == r_total);

    // NOTE: FIFO storage has no reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= exp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_pop && w_mis && STOP_FAIL) w_state_nxt = S_FAIL;
                else if (w_pop && w_last)        w_state_nxt = S_DONE;
            end
            S_FAIL: w_state_nxt = S_FAIL;
            S_DONE: if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_vec_idx    <= '0;
            r_total      <= '0;
            r_match_cnt  <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
            r_chk_pulse  <= 1'b0;
            r_chk_fail   <= 1'b0;
            r_got_dbl    <= '0;
            r_exp_dbl    <= '0;
            r_ovf_err    <= 1'b0;
            r_unf_err    <= 1'b0;
        end else begin
            r_chk_pulse <= w_pop;
            r_chk_fail  <= w_pop && w_mis;
            if (w_start_ok) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_vec_idx    <= '0;
                r_total      <= total_vec;
                r_match_cnt  <= '0;
                r_fail_cnt   <= '0;
                r_first_fail <= '0;
                r_ovf_err    <= 1'b0;
                r_unf_err    <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_ovf)  r_ovf_err <= 1'b1;
                if (w_unf)  r_unf_err <= 1'b1;
                if (w_pop) begin
                    r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                    r_vec_idx <= w_vec_nxt;
                    r_got_dbl <= w_got;
                    r_exp_dbl <= w_exp;
                    if (w_mis) begin
                        if (r_fail_cnt == '0) r_first_fail <= r_vec_idx;
                        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + IDX_W'(1);
                    end else begin
                        r_match_cnt <= r_match_cnt + IDX_W'(1);
                    end
                end
            end
        end
    end

    assign chk_pulse  = r_chk_pulse;
    assign chk_fail   = r_chk_fail;
    assign got_dbl    = r_got_dbl;
    assign exp_dbl    = r_exp_dbl;
    assign match_cnt  = r_match_cnt;
    assign fail_cnt   = r_fail_cnt;
    assign first_fail = r_first_fail;
    assign ovf_err    = r_ovf_err;
    assign unf_err    = r_unf_err;
    assign state      = r_state;

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench for fpu_result_checker: one instance stops on first fail,
// the other only counts; both share the same stimulus.
module tb_fpu_result_checker;

    localparam int IDX_W = 24;

    logic             clk = 1'b0;
    logic             rst, start, exp_valid, dut_valid;
    logic [IDX_W-1:0] total_vec;
    logic [63:0]      exp_data;
    logic [80:0]      dut_res;

    logic             pulse_a, fail_a, ovf_a, unf_a;
    logic [63:0]      got_a, exp_a;
    logic [IDX_W-1:0] match_a, failc_a, ff_a;
    logic [1:0]       state_a;

    logic             pulse_b, fail_b, ovf_b, unf_b;
    logic [63:0]      got_b, exp_b;
    logic [IDX_W-1:0] match_b, failc_b, ff_b;
    logic [1:0]       state_b;

    int n_vec = 0;
    int n_err = 0;
    int mon_pulses, mon_fail_at, cnt_fail_pulses;

    always #5 clk = ~clk;

    fpu_result_checker #(.DEPTH(8), .IDX_W(IDX_W), .STOP_FAIL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .total_vec(total_vec),
        .exp_valid(exp_valid), .exp_data(exp_data), .dut_valid(dut_valid), .dut_res(dut_res),
        .chk_pulse(pulse_a), .chk_fail(fail_a), .got_dbl(got_a), .exp_dbl(exp_a),
        .match_cnt(match_a), .fail_cnt(failc_a), .first_fail(ff_a),
        .ovf_err(ovf_a), .unf_err(unf_a), .state(state_a));

    fpu_result_checker #(.DEPTH(8), .IDX_W(IDX_W), .STOP_FAIL(1'b0)) u_dut_cnt (
        .clk(clk), .rst(rst), .start(start), .total_vec(total_vec),
        .exp_valid(exp_valid), .exp_data(exp_data), .dut_valid(dut_valid), .dut_res(dut_res),
        .chk_pulse(pulse_b), .chk_fail(fail_b), .got_dbl(got_b), .exp_dbl(exp_b),
        .match_cnt(match_b), .fail_cnt(failc_b), .first_fail(ff_b),
        .ovf_err(ovf_b), .unf_err(unf_b), .state(state_b));

    // Pulse monitor samples just after the active edge.
    always @(posedge clk) begin
        #1;
        if (pulse_a) begin
            if (fail_a && mon_fail_at < 0) mon_fail_at = mon_pulses;
            mon_pulses++;
        end
        if (pulse_b && fail_b) cnt_fail_pulses++;
    end

    // Extended form: exp MSB at bit 80; filler bits deliberately non-zero.
    function automatic logic [80:0] to_ext(input logic [63:0] d);
        return {d[62], 16'h5A5A, d[63], ~d[62], d[61:0]};
    endfunction

    task automatic cyc(input bit pv, input logic [63:0] pd, input bit dv, input logic [63:0] dd);
        @(negedge clk);
        exp_valid = pv; exp_data = pd;
        dut_valid = dv; dut_res  = to_ext(dd);
    endtask

    task automatic idle();
        cyc(1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; exp_valid = 1'b0; dut_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mon_pulses = 0; mon_fail_at = -1; cnt_fail_pulses = 0;
    endtask

    task automatic do_start(input int t);
        @(negedge clk);
        start = 1'b1; total_vec = IDX_W'(t);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected stream with the DUT result trailing by 3 cycles.
    task automatic stream(input int n, input logic [63:0] val, input int bad0, input int bad1,
                          input logic [63:0] flip);
        for (int c = 0; c < n + 3; c++) begin
            logic [63:0] d;
            d = val;
            if ((c - 3) == bad0 || (c - 3) == bad1) d = val ^ flip;
            cyc(c < n, val, c >= 3, d);
        end
        idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (state_a !== 2'd0) begin n_err++; $display("FAIL reset state got %0d want 0", state_a); end
        n_vec++; if ({pulse_a, fail_a, ovf_a, unf_a} !== 4'b0) begin n_err++; $display("FAIL reset flags got %b want 0000", {pulse_a, fail_a, ovf_a, unf_a}); end
        n_vec++; if ({match_a, failc_a, ff_a} !== '0) begin n_err++; $display("FAIL reset counts got %h want 0", {match_a, failc_a, ff_a}); end
        n_vec++; if ({got_a, exp_a} !== 128'd0) begin n_err++; $display("FAIL reset dbl got %h want 0", {got_a, exp_a}); end
        do_reset();
    endtask

    task automatic test_all_pass();
        do_reset();
        do_start(16);
        stream(16, 64'h3FF0_0000_0000_0000, -1, -1, 64'd0);
        n_vec++; if (match_a !== 24'd16) begin n_err++; $display("FAIL all_pass match_cnt got %0d want 16", match_a); end
        n_vec++; if (failc_a !== 24'd0) begin n_err++; $display("FAIL all_pass fail_cnt got %0d want 0", failc_a); end
        n_vec++; if (state_a !== 2'd3) begin n_err++; $display("FAIL all_pass state got %0d want 3", state_a); end
        n_vec++; if (mon_pulses !== 16) begin n_err++; $display("FAIL all_pass pulses got %0d want 16", mon_pulses); end
        n_vec++; if (got_a !== 64'h3FF0_0000_0000_0000) begin n_err++; $display("FAIL all_pass got_dbl got %h want 3ff0000000000000", got_a); end
        n_vec++; if ({ovf_a, unf_a} !== 2'b00) begin n_err++; $display("FAIL all_pass errs got %b want 00", {ovf_a, unf_a}); end
    endtask

    task automatic test_restart();
        do_start(4);
        n_vec++; if (state_a !== 2'd1) begin n_err++; $display("FAIL restart state got %0d want 1", state_a); end
        n_vec++; if (match_a !== 24'd0) begin n_err++; $display("FAIL restart match_cnt got %0d want 0", match_a); end
        stream(4, 64'hC000_0000_0000_0000, -1, -1, 64'd0);
        n_vec++; if (state_a !== 2'd3 || match_a !== 24'd4) begin n_err++; $display("FAIL restart end state/match got %0d/%0d want 3/4", state_a, match_a); end
    endtask

    task automatic test_stop_fail();
        do_reset();
        do_start(16);
        stream(16, 64'h4009_21FB_5444_2D18, 5, -1, 64'd1);
        n_vec++; if (mon_fail_at !== 5) begin n_err++; $display("FAIL stop_fail fail pulse at compare %0d want 5", mon_fail_at); end
        n_vec++; if (ff_a !== 24'd5) begin n_err++; $display("FAIL stop_fail first_fail got %0d want 5", ff_a); end
        n_vec++; if (state_a !== 2'd2) begin n_err++; $display("FAIL stop_fail state got %0d want 2", state_a); end
        n_vec++; if (match_a !== 24'd5 || failc_a !== 24'd1) begin n_err++; $display("FAIL stop_fail match/fail got %0d/%0d want 5/1", match_a, failc_a); end
        n_vec++; if (got_a !== 64'h4009_21FB_5444_2D19) begin n_err++; $display("FAIL stop_fail got_dbl got %h want 400921fb54442d19", got_a); end
        n_vec++; if (match_b !== 24'd15 || state_b !== 2'd3) begin n_err++; $display("FAIL stop_fail cnt inst match/state got %0d/%0d want 15/3", match_b, state_b); end
        do_start(4);
        n_vec++; if (state_a !== 2'd2) begin n_err++; $display("FAIL stop_fail start in FAIL state got %0d want 2", state_a); end
    endtask

    task automatic test_count_only();
        do_reset();
        do_start(10);
        stream(10, 64'hBFF8_0000_0000_0000, 2, 7, 64'h8000_0000_0000_0000);
        n_vec++; if (failc_b !== 24'd2) begin n_err++; $display("FAIL count_only fail_cnt got %0d want 2", failc_b); end
        n_vec++; if (ff_b !== 24'd2) begin n_err++; $display("FAIL count_only first_fail got %0d want 2", ff_b); end
        n_vec++; if (match_b !== 24'd8) begin n_err++; $display("FAIL count_only match_cnt got %0d want 8", match_b); end
        n_vec++; if (state_b !== 2'd3) begin n_err++; $display("FAIL count_only state got %0d want 3", state_b); end
        n_vec++; if (cnt_fail_pulses !== 2) begin n_err++; $display("FAIL count_only fail pulses got %0d want 2", cnt_fail_pulses); end
        n_vec++; if (state_a !== 2'd2 || match_a !== 24'd2) begin n_err++; $display("FAIL count_only stop inst state/match got %0d/%0d want 2/2", state_a, match_a); end
    endtask

    task automatic test_fifo_full();
        int p0;
        do_reset();
        do_start(0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 64'd100 + 64'(i), 1'b0, 64'd0);
        cyc(1'b1, 64'd108, 1'b1, 64'd100);
        for (int i = 1; i < 9; i++) cyc(1'b0, 64'd0, 1'b1, 64'd100 + 64'(i));
        idle();
        n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL full_push_pop ovf_err got %b want 0", ovf_a); end
        n_vec++; if (match_a !== 24'd9 || failc_a !== 24'd0) begin n_err++; $display("FAIL full_push_pop match/fail got %0d/%0d want 9/0", match_a, failc_a); end
        for (int i = 0; i < 9; i++) cyc(1'b1, 64'd200 + 64'(i), 1'b0, 64'd0);
        idle();
        n_vec++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL overflow ovf_err got %b want 1", ovf_a); end
        for (int i = 0; i < 8; i++) cyc(1'b0, 64'd0, 1'b1, 64'd200 + 64'(i));
        idle();
        n_vec++; if (match_a !== 24'd17 || unf_a !== 1'b0) begin n_err++; $display("FAIL overflow retained match/unf got %0d/%b want 17/0", match_a, unf_a); end
        p0 = mon_pulses;
        cyc(1'b0, 64'd0, 1'b1, 64'd208);
        idle();
        n_vec++; if (unf_a !== 1'b1 || mon_pulses !== p0) begin n_err++; $display("FAIL overflow dropped unf/pulses got %b/%0d want 1/%0d", unf_a, mon_pulses, p0); end
    endtask

    task automatic test_underflow();
        do_reset();
        do_start(0);
        cyc(1'b1, 64'h4000_0000_0000_0000, 1'b1, 64'h4000_0000_0000_0000);
        idle();
        n_vec++; if (unf_a !== 1'b1 || pulse_a !== 1'b0) begin n_err++; $display("FAIL underflow unf/pulse got %b/%b want 1/0", unf_a, pulse_a); end
        cyc(1'b0, 64'd0, 1'b1, 64'h4000_0000_0000_0000);
        idle();
        n_vec++; if (pulse_a !== 1'b1 || fail_a !== 1'b0) begin n_err++; $display("FAIL underflow follow pulse/fail got %b/%b want 1/0", pulse_a, fail_a); end
        n_vec++; if (exp_a !== 64'h4000_0000_0000_0000 || match_a !== 24'd1) begin n_err++; $display("FAIL underflow follow exp/match got %h/%0d want 4000000000000000/1", exp_a, match_a); end
    endtask

    task automatic test_zero_and_reset();
        do_reset();
        do_start(0);
        cyc(1'b1, 64'd0, 1'b0, 64'd0);
        cyc(1'b0, 64'd0, 1'b1, 64'h8000_0000_0000_0000);
        idle();
        n_vec++; if (pulse_b !== 1'b1 || fail_b !== 1'b1) begin n_err++; $display("FAIL signed_zero pulse/fail got %b/%b want 1/1", pulse_b, fail_b); end
        n_vec++; if (got_b !== 64'h8000_0000_0000_0000 || exp_b !== 64'd0) begin n_err++; $display("FAIL signed_zero got/exp got %h/%h want 8000000000000000/0", got_b, exp_b); end
        n_vec++; if (state_b !== 2'd1 || failc_b !== 24'd1) begin n_err++; $display("FAIL signed_zero state/fail_cnt got %0d/%0d want 1/1", state_b, failc_b); end
        cyc(1'b1, 64'd7, 1'b0, 64'd0);
        @(negedge clk);
        rst = 1'b1; exp_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (state_b !== 2'd0 || state_a !== 2'd0) begin n_err++; $display("FAIL mid_reset states got %0d/%0d want 0/0", state_a, state_b); end
        n_vec++; if ({match_b, failc_b, ff_b} !== '0) begin n_err++; $display("FAIL mid_reset counts got %h want 0", {match_b, failc_b, ff_b}); end
        n_vec++; if ({pulse_b, fail_b, ovf_b, unf_b} !== 4'b0 || got_b !== 64'd0) begin n_err++; $display("FAIL mid_reset flags/got got %b/%h want 0000/0", {pulse_b, fail_b, ovf_b, unf_b}, got_b); end
        rst = 1'b0;
        do_start(0);
        cyc(1'b0, 64'd0, 1'b1, 64'd7);
        idle();
        n_vec++; if (unf_b !== 1'b1 || pulse_b !== 1'b0) begin n_err++; $display("FAIL mid_reset fifo_cleared unf/pulse got %b/%b want 1/0", unf_b, pulse_b); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; total_vec = '0;
        exp_valid = 1'b0; exp_data = '0; dut_valid = 1'b0; dut_res = '0;
        mon_pulses = 0; mon_fail_at = -1; cnt_fail_pulses = 0;
        test_reset();
        test_all_pass();
        test_restart();
        test_stop_fail();
        test_count_only();
        test_fifo_full();
        test_underflow();
        test_zero_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
